// File: rtl/free_list.sv
// Circular free list of physical register tags for a 4-wide rename stage.
// Allocation is compacted by slot order; retired tags return at the tail; flush restores head to tail.
module free_list #(
    parameter int unsigned DEPTH     = 96,
    parameter int unsigned PHYS_BASE = 32
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [3:0] alloc_req_i,
    output logic       alloc_ready_o,
    output logic [6:0] inst0_rdphys_o,
    output logic [6:0] inst1_rdphys_o,
    output logic [6:0] inst2_rdphys_o,
    output logic [6:0] inst3_rdphys_o,
    input  logic [3:0] retire_valid_i,
    input  logic [6:0] retire0_oldrdphys_i,
    input  logic [6:0] retire1_oldrdphys_i,
    input  logic [6:0] retire2_oldrdphys_i,
    input  logic [6:0] retire3_oldrdphys_i,
    input  logic       flush_i,
    output logic [6:0] free_count_o,
    output logic       err_o
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam logic [PW:0]   DEPTH_P = (PW + 1)'(DEPTH);
    localparam logic [CW:0]   DEPTH_W = (CW + 1)'(DEPTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    function automatic logic [2:0] popcnt4(input logic [3:0] v);
        return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
    endfunction

    // Offsets never exceed 4, so one conditional subtraction wraps correctly.
    function automatic logic [PW-1:0] ptr_add(input logic [PW-1:0] p, input logic [2:0] off);
        logic [PW:0] s;
        s = {1'b0, p} + (PW + 1)'(off);
        if (s >= DEPTH_P) s = s - DEPTH_P;
        return s[PW-1:0];
    endfunction

    logic [6:0]    mem_q [DEPTH];
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic          err_q, err_d;

    logic [2:0]    nreq, nret;
    logic          alloc_fire;
    logic          overflow;
    logic [CW:0]   cnt_sum;
    logic [6:0]    ret_tag [4];
    logic [6:0]    rd_tag  [4];
    logic [PW-1:0] wr_addr [4];

    assign ret_tag[0] = retire0_oldrdphys_i;
    assign ret_tag[1] = retire1_oldrdphys_i;
    assign ret_tag[2] = retire2_oldrdphys_i;
    assign ret_tag[3] = retire3_oldrdphys_i;

    assign nreq          = popcnt4(alloc_req_i);
    assign nret          = popcnt4(retire_valid_i);
    assign alloc_ready_o = ({1'b0, count_q} >= (CW + 1)'(nreq)) & ~flush_i;
    assign alloc_fire    = alloc_ready_o & (nreq != 3'd0);

    always_comb begin
        logic [3:0] lo_mask;
        for (int k = 0; k < 4; k++) begin
            lo_mask    = 4'((1 << k) - 1);
            rd_tag[k]  = alloc_req_i[k]
                       ? mem_q[ptr_add(head_q, popcnt4(alloc_req_i & lo_mask))] : 7'd0;
            wr_addr[k] = ptr_add(tail_q, popcnt4(retire_valid_i & lo_mask));
        end
    end

    assign inst0_rdphys_o = rd_tag[0];
    assign inst1_rdphys_o = rd_tag[1];
    assign inst2_rdphys_o = rd_tag[2];
    assign inst3_rdphys_o = rd_tag[3];

    always_comb begin
        cnt_sum  = {1'b0, count_q} - (alloc_fire ? (CW + 1)'(nreq) : '0) + (CW + 1)'(nret);
        overflow = cnt_sum > DEPTH_W;
        err_d    = err_q | overflow;
        tail_d   = ptr_add(tail_q, nret);
        head_d   = head_q;
        count_d  = overflow ? DEPTH_C : cnt_sum[CW-1:0];
        if (flush_i) begin
            // Committed head always equals tail, so recovery just snaps head to it.
            head_d  = tail_d;
            count_d = DEPTH_C;
        end else if (alloc_fire) begin
            head_d = ptr_add(head_q, nreq);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= 7'(PHYS_BASE + i);
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= DEPTH_C;
            err_q   <= 1'b0;
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (retire_valid_i[k]) mem_q[wr_addr[k]] <= ret_tag[k];
            end
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    assign free_count_o = 7'(count_q);
    assign err_o        = err_q;

endmodule

// File: tb/tb_free_list.sv
// Self-checking bench for free_list: a vector table driven through a scoreboard queue,
// followed by hand-written multi-cycle sequences for drain, wrap, flush and error cases.
module tb_free_list;

    logic       clk = 1'b0;
    logic       rst_i;
    logic [3:0] alloc_req_i;
    logic       alloc_ready_o;
    logic [6:0] inst0_rdphys_o, inst1_rdphys_o, inst2_rdphys_o, inst3_rdphys_o;
    logic [3:0] retire_valid_i;
    logic [6:0] retire0_oldrdphys_i, retire1_oldrdphys_i;
    logic [6:0] retire2_oldrdphys_i, retire3_oldrdphys_i;
    logic       flush_i;
    logic [6:0] free_count_o;
    logic       err_o;

    always #5 clk = ~clk;

    free_list #(.DEPTH(96), .PHYS_BASE(32)) dut (
        .clk_i               (clk),
        .rst_i               (rst_i),
        .alloc_req_i         (alloc_req_i),
        .alloc_ready_o       (alloc_ready_o),
        .inst0_rdphys_o      (inst0_rdphys_o),
        .inst1_rdphys_o      (inst1_rdphys_o),
        .inst2_rdphys_o      (inst2_rdphys_o),
        .inst3_rdphys_o      (inst3_rdphys_o),
        .retire_valid_i      (retire_valid_i),
        .retire0_oldrdphys_i (retire0_oldrdphys_i),
        .retire1_oldrdphys_i (retire1_oldrdphys_i),
        .retire2_oldrdphys_i (retire2_oldrdphys_i),
        .retire3_oldrdphys_i (retire3_oldrdphys_i),
        .flush_i             (flush_i),
        .free_count_o        (free_count_o),
        .err_o               (err_o)
    );

    typedef struct packed {
        logic            ready;
        logic [3:0][6:0] tg;
        logic [6:0]      cnt;
        logic            err;
    } exp_t;

    typedef struct packed {
        logic [3:0]      req;
        logic [3:0]      rv;
        logic [3:0][6:0] rt;
        logic            fl;
        exp_t            e;
    } vec_t;

    exp_t sb[$];
    int   tagq[$];
    vec_t tbl[11];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic chk7(input string nm, input logic [6:0] act, input logic [6:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, req);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0b, expected %0b", nm, act, req);
        end
    endtask

    function automatic exp_t mk_e(input logic r, input logic [3:0][6:0] t,
                                  input logic [6:0] c, input logic er);
        exp_t e;
        e.ready = r;
        e.tg    = t;
        e.cnt   = c;
        e.err   = er;
        return e;
    endfunction

    function automatic vec_t mk_v(input logic [3:0] req, input logic [3:0] rv,
                                  input logic [3:0][6:0] rt, input logic fl, input exp_t e);
        vec_t v;
        v.req = req;
        v.rv  = rv;
        v.rt  = rt;
        v.fl  = fl;
        v.e   = e;
        return v;
    endfunction

    task automatic drive(input logic [3:0] req, input logic [3:0] rv,
                         input logic [3:0][6:0] rt, input logic fl);
        alloc_req_i         = req;
        retire_valid_i      = rv;
        retire0_oldrdphys_i = rt[0];
        retire1_oldrdphys_i = rt[1];
        retire2_oldrdphys_i = rt[2];
        retire3_oldrdphys_i = rt[3];
        flush_i             = fl;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive(4'b0, 4'b0, '0, 1'b0);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
    endtask

    // Pops the oldest expectation and compares it against the settled outputs.
    task automatic sb_check(input string nm);
        exp_t e;
        #4;
        e = sb.pop_front();
        chk1({nm, " ready"}, alloc_ready_o, e.ready);
        chk7({nm, " inst0"}, inst0_rdphys_o, e.tg[0]);
        chk7({nm, " inst1"}, inst1_rdphys_o, e.tg[1]);
        chk7({nm, " inst2"}, inst2_rdphys_o, e.tg[2]);
        chk7({nm, " inst3"}, inst3_rdphys_o, e.tg[3]);
        chk7({nm, " count"}, free_count_o, e.cnt);
        chk1({nm, " err"}, err_o, e.err);
    endtask

    initial begin
        rst_i = 1'b1;
        drive(4'b0, 4'b0, '0, 1'b0);

        tbl[0]  = mk_v(4'b0000, 4'b0000, '0, 1'b0, mk_e(1'b1, '0, 7'd96, 1'b0));
        tbl[1]  = mk_v(4'b1111, 4'b0000, '0, 1'b0,
                       mk_e(1'b1, {7'd35, 7'd34, 7'd33, 7'd32}, 7'd96, 1'b0));
        tbl[2]  = mk_v(4'b0000, 4'b0000, '0, 1'b0, mk_e(1'b1, '0, 7'd92, 1'b0));
        tbl[3]  = mk_v(4'b1010, 4'b0000, '0, 1'b0,
                       mk_e(1'b1, {7'd37, 7'd0, 7'd36, 7'd0}, 7'd92, 1'b0));
        tbl[4]  = mk_v(4'b0001, 4'b0000, '0, 1'b0,
                       mk_e(1'b1, {7'd0, 7'd0, 7'd0, 7'd38}, 7'd90, 1'b0));
        tbl[5]  = mk_v(4'b0110, 4'b0011, {7'd0, 7'd0, 7'd4, 7'd3}, 1'b0,
                       mk_e(1'b1, {7'd0, 7'd40, 7'd39, 7'd0}, 7'd89, 1'b0));
        tbl[6]  = mk_v(4'b0100, 4'b0000, '0, 1'b1,
                       mk_e(1'b0, {7'd0, 7'd41, 7'd0, 7'd0}, 7'd89, 1'b0));
        tbl[7]  = mk_v(4'b1111, 4'b0000, '0, 1'b0,
                       mk_e(1'b1, {7'd37, 7'd36, 7'd35, 7'd34}, 7'd96, 1'b0));
        tbl[8]  = mk_v(4'b0000, 4'b0000, '0, 1'b0, mk_e(1'b1, '0, 7'd92, 1'b0));
        tbl[9]  = mk_v(4'b1111, 4'b1111, {7'd13, 7'd12, 7'd11, 7'd10}, 1'b0,
                       mk_e(1'b1, {7'd41, 7'd40, 7'd39, 7'd38}, 7'd92, 1'b0));
        tbl[10] = mk_v(4'b0000, 4'b0000, '0, 1'b0, mk_e(1'b1, '0, 7'd92, 1'b0));

        // Vector table straight out of reset.
        do_reset();
        for (int i = 0; i < 11; i++) begin
            drive(tbl[i].req, tbl[i].rv, tbl[i].rt, tbl[i].fl);
            sb.push_back(tbl[i].e);
            sb_check($sformatf("vec%0d", i));
            tick();
        end

        // Compaction of a sparse request, then the next tag in order.
        do_reset();
        drive(4'b1010, 4'b0, '0, 1'b0);
        sb.push_back(mk_e(1'b1, {7'd33, 7'd0, 7'd32, 7'd0}, 7'd96, 1'b0));
        sb_check("sparse");
        tick();
        drive(4'b0001, 4'b0, '0, 1'b0);
        #4;
        chk7("sparse_next inst0", inst0_rdphys_o, 7'd34);
        tick();

        // Drain to two free tags; a three-wide request must stall without side effects.
        do_reset();
        for (int c = 0; c < 23; c++) begin
            drive(4'b1111, 4'b0, '0, 1'b0);
            tick();
        end
        drive(4'b0011, 4'b0, '0, 1'b0);
        tick();
        drive(4'b0111, 4'b0, '0, 1'b0);
        #4;
        chk1("short ready", alloc_ready_o, 1'b0);
        chk7("short count", free_count_o, 7'd2);
        tick();
        drive(4'b0011, 4'b0, '0, 1'b0);
        #4;
        chk7("short hold count", free_count_o, 7'd2);
        chk1("short2 ready", alloc_ready_o, 1'b1);
        chk7("short2 inst0", inst0_rdphys_o, 7'd126);
        chk7("short2 inst1", inst1_rdphys_o, 7'd127);
        tick();
        drive(4'b0001, 4'b0, '0, 1'b0);
        #4;
        chk7("empty count", free_count_o, 7'd0);
        chk1("empty ready", alloc_ready_o, 1'b0);
        tick();

        // Pointer wrap: keep the list full while walking head to entry 94.
        do_reset();
        for (int c = 0; c < 23; c++) begin
            drive(4'b1111, 4'b1111,
                  {7'(4 * c + 3), 7'(4 * c + 2), 7'(4 * c + 1), 7'(4 * c)}, 1'b0);
            tick();
        end
        drive(4'b0011, 4'b0011, {7'd0, 7'd0, 7'd93, 7'd92}, 1'b0);
        tick();
        drive(4'b1111, 4'b0, '0, 1'b0);
        sb.push_back(mk_e(1'b1, {7'd1, 7'd0, 7'd127, 7'd126}, 7'd96, 1'b0));
        sb_check("wrap");
        tick();
        drive(4'b0001, 4'b0, '0, 1'b0);
        #4;
        chk7("wrap head2 inst0", inst0_rdphys_o, 7'd2);
        chk7("wrap count", free_count_o, 7'd92);
        tick();

        // Flush with same-cycle retires: returned tags come back only after 94 others.
        do_reset();
        drive(4'b1111, 4'b0, '0, 1'b0);
        tick();
        drive(4'b1111, 4'b0, '0, 1'b0);
        tick();
        drive(4'b0000, 4'b0011, {7'd0, 7'd0, 7'd9, 7'd5}, 1'b1);
        #4;
        chk1("flush ready", alloc_ready_o, 1'b0);
        chk7("flush pre count", free_count_o, 7'd88);
        tick();
        drive(4'b0, 4'b0, '0, 1'b0);
        #4;
        chk7("flush count", free_count_o, 7'd96);
        chk1("flush err", err_o, 1'b0);
        tick();
        for (int t = 34; t < 128; t++) tagq.push_back(t);
        tagq.push_back(5);
        tagq.push_back(9);
        for (int j = 0; j < 48; j++) begin
            drive(4'b0011, 4'b0, '0, 1'b0);
            #4;
            chk1($sformatf("flush_seq%0d ready", j), alloc_ready_o, 1'b1);
            chk7($sformatf("flush_seq%0d inst0", j), inst0_rdphys_o, 7'(tagq.pop_front()));
            chk7($sformatf("flush_seq%0d inst1", j), inst1_rdphys_o, 7'(tagq.pop_front()));
            tick();
        end

        // Retire into a full list sets a sticky error that only reset clears.
        do_reset();
        drive(4'b0000, 4'b0001, {7'd0, 7'd0, 7'd0, 7'd50}, 1'b0);
        #4;
        chk1("err pre", err_o, 1'b0);
        tick();
        drive(4'b0, 4'b0, '0, 1'b0);
        #4;
        chk1("err set", err_o, 1'b1);
        tick();
        drive(4'b0, 4'b0, '0, 1'b1);
        tick();
        drive(4'b0011, 4'b0, '0, 1'b0);
        tick();
        drive(4'b0, 4'b0, '0, 1'b0);
        #4;
        chk1("err sticky", err_o, 1'b1);
        tick();
        // Reset wins over concurrent flush, allocation and retire.
        rst_i = 1'b1;
        drive(4'b1111, 4'b1111, {7'd1, 7'd2, 7'd3, 7'd4}, 1'b1);
        tick();
        rst_i = 1'b0;
        drive(4'b1111, 4'b0, '0, 1'b0);
        sb.push_back(mk_e(1'b1, {7'd35, 7'd34, 7'd33, 7'd32}, 7'd96, 1'b0));
        sb_check("reset_prio");
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
